// File: rtl/output_pooling_addr_seq.sv
// output_pooling_addr_seq
//
// Sequential output-pooling address generator. A start pulse latches one layer's
// output geometry and the block then walks every output point (column fastest,
// then row, then channel from start to end index). Each point is issued as one
// beat carrying the BRAM bank select and the in-bank address over a valid/ready
// handshake. Addressing is incremental: a single size*size product is formed at
// latch time, and the walk itself uses only adders and comparators.
//
// Ports:
//   i_clk                         clock, rising edge
//   i_rst_n                       synchronous active-low reset
//   i_start                       start pulse, honoured only in IDLE
//   i_pooling_enable              selects pooled (1) or conv (0) map size
//   i_output_pooling_size         pooled map side length
//   i_output_conv_size            un-pooled map side length
//   i_output_start_index_channel  first channel
//   i_output_end_index_channel    last channel, inclusive
//   i_addr_ready                  consumer ready
//   o_addr_valid                  beat valid
//   o_output_address              in-bank address
//   o_output_bank_sel             target bank
//   o_output_channel              current channel
//   o_output_row                  current row
//   o_output_col                  current column
//   o_last                        final beat of the layer (qualified by o_addr_valid)
//   o_busy                        walk in progress
//   o_done                        one-cycle completion pulse
//   o_cfg_err                     one-cycle illegal-configuration pulse, with o_done

module output_pooling_addr_seq #(
  parameter int unsigned OUTPUT_CHANNEL_WIDTH      = 7,
  parameter int unsigned OUTPUT_ROW_WIDTH          = 4,
  parameter int unsigned OUTPUT_COL_WIDTH          = 4,
  parameter int unsigned OUTPUT_BRAM_NUM           = 4,
  parameter int unsigned OUTPUT_BRAM_DEPTH         = 1152,
  parameter int unsigned OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
  parameter int unsigned BANK_SEL_WIDTH            =
      (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic                                 i_pooling_enable,
  input  logic [OUTPUT_COL_WIDTH-1:0]          i_output_pooling_size,
  input  logic [OUTPUT_COL_WIDTH-1:0]          i_output_conv_size,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_output_start_index_channel,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_output_end_index_channel,
  input  logic                                 i_addr_ready,
  output logic                                 o_addr_valid,
  output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_output_address,
  output logic [BANK_SEL_WIDTH-1:0]            o_output_bank_sel,
  output logic [OUTPUT_CHANNEL_WIDTH-1:0]      o_output_channel,
  output logic [OUTPUT_ROW_WIDTH-1:0]          o_output_row,
  output logic [OUTPUT_COL_WIDTH-1:0]          o_output_col,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_cfg_err
);

  localparam int unsigned ChW  = OUTPUT_CHANNEL_WIDTH;
  localparam int unsigned RowW = OUTPUT_ROW_WIDTH;
  localparam int unsigned ColW = OUTPUT_COL_WIDTH;
  localparam int unsigned AddrW = OUTPUT_BRAM_ADDRESS_WIDTH;
  localparam int unsigned BankW = BANK_SEL_WIDTH;
  localparam int unsigned SqW  = 2 * ColW;
  // Common width for comparing the row index against the column-width size.
  localparam int unsigned DimW = (RowW > ColW) ? RowW : ColW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ColW-1:0]       size_q, size_d;
  logic [SqW-1:0]        size_sq_q, size_sq_d;
  logic [ChW-1:0]        end_q, end_d;
  logic [ChW-1:0]        ch_q, ch_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [BankW-1:0]      bank_q, bank_d;
  logic [AddrW-1:0]      base_q, base_d;
  logic [AddrW-1:0]      addr_q, addr_d;
  logic                  err_q, err_d;

  logic [ColW-1:0]       size_sel;
  logic [ColW-1:0]       size_m1;
  logic [AddrW-1:0]      size_sq_ext;
  logic [BankW-1:0]      bank_inc;
  logic                  bank_wrap;
  logic                  col_end;
  logic                  row_end;
  logic                  last_point;

  // Fit the latched size*size product to the address width (zero-extend or truncate).
  if (SqW >= AddrW) begin : g_sq_trunc
    assign size_sq_ext = size_sq_q[AddrW-1:0];
  end else begin : g_sq_ext
    assign size_sq_ext = {{(AddrW - SqW){1'b0}}, size_sq_q};
  end

  // With a single bank every channel step wraps the bank and advances the base.
  if (OUTPUT_BRAM_NUM == 1) begin : g_one_bank
    assign bank_inc = '0;
  end else begin : g_multi_bank
    // BankW == log2(OUTPUT_BRAM_NUM), so the natural overflow is the modulo.
    assign bank_inc = bank_q + 1'b1;
  end

  assign bank_wrap  = (bank_inc == '0);
  assign size_sel   = i_pooling_enable ? i_output_pooling_size : i_output_conv_size;
  assign size_m1    = size_q - 1'b1;
  assign col_end    = (col_q == size_m1);
  assign row_end    = (DimW'(row_q) == DimW'(size_m1));
  assign last_point = (ch_q == end_q) && row_end && col_end;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    size_sq_d = size_sq_q;
    end_d     = end_q;
    ch_d      = ch_q;
    row_d     = row_q;
    col_d     = col_q;
    bank_d    = bank_q;
    base_d    = base_q;
    addr_d    = addr_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (i_start) begin
          size_d    = size_sel;
          size_sq_d = SqW'(size_sel) * SqW'(size_sel);
          end_d     = i_output_end_index_channel;
          ch_d      = i_output_start_index_channel;
          row_d     = '0;
          col_d     = '0;
          bank_d    = '0;
          base_d    = '0;
          addr_d    = '0;
          if ((i_output_end_index_channel < i_output_start_index_channel) ||
              (size_sel == '0)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (i_addr_ready) begin
          if (last_point) begin
            state_d = StDone;
          end else if (!col_end) begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else if (!row_end) begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            // Channel step: next bank; the base only moves once all banks are used.
            col_d  = '0;
            row_d  = '0;
            ch_d   = ch_q + 1'b1;
            bank_d = bank_inc;
            if (bank_wrap) begin
              base_d = base_q + size_sq_ext;
              addr_d = base_q + size_sq_ext;
            end else begin
              addr_d = base_q;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      size_q    <= '0;
      size_sq_q <= '0;
      end_q     <= '0;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bank_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      size_sq_q <= size_sq_d;
      end_q     <= end_d;
      ch_q      <= ch_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bank_q    <= bank_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  assign o_addr_valid      = (state_q == StRun);
  assign o_busy            = (state_q == StRun);
  assign o_done            = (state_q == StDone);
  assign o_cfg_err         = (state_q == StDone) && err_q;
  assign o_last            = (state_q == StRun) && last_point;
  assign o_output_address  = addr_q;
  assign o_output_bank_sel = bank_q;
  assign o_output_channel  = ch_q;
  assign o_output_row      = row_q;
  assign o_output_col      = col_q;

endmodule

// File: tb/tb_output_pooling_addr_seq.sv
// Testbench for output_pooling_addr_seq: directed scenarios plus randomized layers,
// checked against a closed-form model of the output point walk.

module tb_output_pooling_addr_seq;

  localparam int unsigned ChW   = 7;
  localparam int unsigned RowW  = 4;
  localparam int unsigned ColW  = 4;
  localparam int unsigned NBank = 4;
  localparam int unsigned Depth = 1152;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned BankW = (NBank > 1) ? $clog2(NBank) : 1;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [BankW-1:0] bank;
    logic [ChW-1:0]   ch;
    logic [RowW-1:0]  row;
    logic [ColW-1:0]  col;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             pool_en;
  logic [ColW-1:0]  pool_size;
  logic [ColW-1:0]  conv_size;
  logic [ChW-1:0]   ch_start;
  logic [ChW-1:0]   ch_end;
  logic             ready;
  logic             valid;
  logic [AddrW-1:0] addr;
  logic [BankW-1:0] bank;
  logic [ChW-1:0]   ch;
  logic [RowW-1:0]  row;
  logic [ColW-1:0]  col;
  logic             last;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int n_assert = 0;
  int n_fail   = 0;

  output_pooling_addr_seq #(
    .OUTPUT_CHANNEL_WIDTH (ChW),
    .OUTPUT_ROW_WIDTH     (RowW),
    .OUTPUT_COL_WIDTH     (ColW),
    .OUTPUT_BRAM_NUM      (NBank),
    .OUTPUT_BRAM_DEPTH    (Depth)
  ) dut (
    .i_clk                        (clk),
    .i_rst_n                      (rst_n),
    .i_start                      (start),
    .i_pooling_enable             (pool_en),
    .i_output_pooling_size        (pool_size),
    .i_output_conv_size           (conv_size),
    .i_output_start_index_channel (ch_start),
    .i_output_end_index_channel   (ch_end),
    .i_addr_ready                 (ready),
    .o_addr_valid                 (valid),
    .o_output_address             (addr),
    .o_output_bank_sel            (bank),
    .o_output_channel             (ch),
    .o_output_row                 (row),
    .o_output_col                 (col),
    .o_last                       (last),
    .o_busy                       (busy),
    .o_done                       (done),
    .o_cfg_err                    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 ready low 3 cycles before every 4th beat, 2 random.
  // disturb: re-pulse start with new config at beat 4. reset_at: beat index to reset at.
  task automatic run_layer(input bit pen, input int psz, input int csz, input int st,
                           input int en, input int rmode, input bit disturb,
                           input int reset_at);
    beat_t exp_q[$];
    beat_t cur;
    beat_t prev;
    int    s;
    bit    err;
    int    n;
    int    idx;
    int    cyc;
    int    budget;
    int    stall_cnt;
    int    stalled_for;
    bit    prev_stalled;
    bit    done_seen;
    bit    disturbed;

    s   = pen ? psz : csz;
    err = (en < st) || (s == 0);
    if (!err) begin
      for (int c = st; c <= en; c++) begin
        for (int r = 0; r < s; r++) begin
          for (int k = 0; k < s; k++) begin
            exp_q.push_back('{addr: AddrW'(((c - st) / NBank) * s * s + r * s + k),
                              bank: BankW'((c - st) % NBank),
                              ch:   ChW'(c), row: RowW'(r), col: ColW'(k)});
          end
        end
      end
    end
    n            = exp_q.size();
    budget       = n * 6 + 20;
    idx          = 0;
    cyc          = 0;
    stall_cnt    = 0;
    stalled_for  = -1;
    prev_stalled = 1'b0;
    done_seen    = 1'b0;
    disturbed    = 1'b0;
    prev         = '0;

    @(negedge clk);
    pool_en   = pen;
    pool_size = ColW'(psz);
    conv_size = ColW'(csz);
    ch_start  = ChW'(st);
    ch_end    = ChW'(en);
    start     = 1'b1;
    ready     = 1'b0;

    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;

      if (reset_at >= 0 && valid && idx == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_beat", {addr, bank, ch, row, col}, '0);
        chk("rst_flags", {last, busy, done, cfg_err}, 4'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("rst_no_done", done, 1'b0);
          chk("rst_idle_valid", valid, 1'b0);
        end
        return;
      end

      if (disturb && !disturbed && idx == 3) begin
        start     = 1'b1;
        pool_en   = $urandom_range(0, 1) == 1;
        pool_size = ColW'($urandom_range(1, 6));
        conv_size = ColW'($urandom_range(1, 6));
        ch_start  = ChW'($urandom_range(0, 20));
        ch_end    = ChW'($urandom_range(0, 20));
        disturbed = 1'b1;
      end

      case (rmode)
        0: ready = 1'b1;
        1: begin
          if (idx % 4 == 3 && stalled_for != idx) begin
            stall_cnt   = 3;
            stalled_for = idx;
          end
          ready = (stall_cnt == 0);
          if (stall_cnt > 0) stall_cnt--;
        end
        default: ready = ($urandom_range(0, 3) != 0);
      endcase

      if (valid) begin
        cur = {addr, bank, ch, row, col};
        if (idx < n) begin
          chk("beat", cur, exp_q[idx]);
          chk("last", last, (idx == n - 1));
        end else begin
          chk("extra_beat", idx, n - 1);
        end
        chk("busy", busy, 1'b1);
        chk("addr_in_depth", (int'(addr) < Depth), 1'b1);
        if (prev_stalled) chk("stall_hold", cur, prev);
        prev         = cur;
        prev_stalled = !ready;
        if (ready) idx++;
      end else if (done) begin
        done_seen = 1'b1;
        chk("beat_count", idx, n);
        chk("cfg_err", cfg_err, err);
        chk("done_busy", busy, 1'b0);
        if (err) chk("err_latency", cyc, 1);
        else if (rmode == 0) chk("done_latency", cyc, n + 1);
      end else begin
        chk("idle_gap", done, 1'b1);
      end
    end

    if (!done_seen) chk("timeout", done_seen, 1'b1);

    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("post_err", cfg_err, 1'b0);
    chk("post_valid", valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pool_en   = 1'b0;
    pool_size = '0;
    conv_size = '0;
    ch_start  = '0;
    ch_end    = '0;
    ready     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 1'b0);
    chk("reset_beat", {addr, bank, ch, row, col}, '0);
    chk("reset_flags", {last, busy, done, cfg_err}, 4'b0);
    rst_n = 1'b1;

    // Pooled 2x2, channels 0..7, ready high.
    run_layer(1'b1, 2, 9, 0, 7, 0, 1'b0, -1);
    // Conv 3x3 single channel 5 (pool size must be ignored).
    run_layer(1'b0, 2, 3, 5, 5, 0, 1'b0, -1);
    // Pooled 2x2 with periodic stalls.
    run_layer(1'b1, 2, 9, 0, 7, 1, 1'b0, -1);
    // Illegal configurations.
    run_layer(1'b1, 2, 3, 8, 3, 0, 1'b0, -1);
    run_layer(1'b1, 0, 3, 0, 3, 0, 1'b0, -1);
    run_layer(1'b0, 2, 0, 0, 3, 0, 1'b0, -1);
    // Reset at beat 10, then a clean restart.
    run_layer(1'b1, 2, 9, 0, 7, 0, 1'b0, 9);
    run_layer(1'b1, 2, 9, 0, 7, 0, 1'b0, -1);
    // Start re-pulsed with changed config mid-run.
    run_layer(1'b0, 2, 3, 5, 5, 0, 1'b1, -1);

    for (int t = 0; t < 8; t++) begin
      int st;
      int en;
      st = $urandom_range(0, 100);
      en = st + $urandom_range(0, 27);
      run_layer($urandom_range(0, 1) == 1, $urandom_range(1, 6), $urandom_range(1, 6),
                st, en, 2, ($urandom_range(0, 3) == 0), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
